// File: rtl/lsu_prf_wb_sched.sv
// Load writeback scheduler: merges two d$ pipes and the bus into one registered PRF write port.
// Optional bus anti-starvation is enabled with the LSU_WB_SCHED_BUS_AGE_EN macro.
module lsu_prf_wb_sched #(
    parameter int XLEN               = 64,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int BUF_DEPTH          = 4,
    parameter int BUS_STARVE_LIMIT   = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              flush,
    input  logic [1:0]                        l1d_sched_wb_vld_i,
    input  logic [2*PHY_REG_ADDR_WIDTH-1:0]   l1d_sched_wb_rd_addr_i,
    input  logic [2*XLEN-1:0]                 l1d_sched_wb_data_i,
    output logic                              sched_l1d_rdy_o,
    input  logic                              bus_sched_wb_vld_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]     bus_sched_wb_rd_addr_i,
    input  logic [XLEN-1:0]                   bus_sched_wb_data_i,
    output logic                              sched_bus_rdy_o,
    output logic                              sched_prf_wb_vld_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]     sched_prf_wb_rd_addr_o,
    output logic [XLEN-1:0]                   sched_prf_wb_data_o,
    output logic [$clog2(BUF_DEPTH):0]        sched_buf_cnt_o
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = PHY_REG_ADDR_WIDTH;

    if (BUF_DEPTH < 4 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 ||
        BUS_STARVE_LIMIT < 1 || BUS_STARVE_LIMIT > 255) begin : g_bad_cfg
    end

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_buf_addr [BUF_DEPTH];
    logic [XLEN-1:0] r_buf_data [BUF_DEPTH];

    logic            r_prf_vld_p1;
    logic [AW-1:0]   r_prf_addr_p1;
    logic [XLEN-1:0] r_prf_data_p1;

    logic            w_room;
    logic            w_empty;
    logic            w_v0;
    logic            w_v1;
    logic [AW-1:0]   w_p0_addr;
    logic [AW-1:0]   w_p1_addr;
    logic [XLEN-1:0] w_p0_data;
    logic [XLEN-1:0] w_p1_data;
    logic            w_starve;
    logic            w_bus_gnt;
    logic            w_deq;
    logic            w_enq0;
    logic            w_enq1;
    logic [1:0]      w_enq_n;
    logic [PW-1:0]   w_wr_ptr_b;
    logic            w_sel_vld;
    logic [AW-1:0]   w_sel_addr;
    logic [XLEN-1:0] w_sel_data;

    assign w_room    = (r_cnt <= CW'(BUF_DEPTH - 2));
    assign w_empty   = (r_cnt == '0);
    // A d$ valid offered while not ready is a protocol violation and is ignored.
    assign w_v0      = l1d_sched_wb_vld_i[0] & w_room;
    assign w_v1      = l1d_sched_wb_vld_i[1] & w_room;
    assign w_p0_addr = l1d_sched_wb_rd_addr_i[AW-1:0];
    assign w_p1_addr = l1d_sched_wb_rd_addr_i[2*AW-1:AW];
    assign w_p0_data = l1d_sched_wb_data_i[XLEN-1:0];
    assign w_p1_data = l1d_sched_wb_data_i[2*XLEN-1:XLEN];

    assign sched_l1d_rdy_o = ~rstn | w_room;
    assign sched_bus_rdy_o = w_bus_gnt;
    assign sched_buf_cnt_o = r_cnt;

`ifdef LSU_WB_SCHED_BUS_AGE_EN
    logic [7:0] r_starve_cnt;

    assign w_starve = bus_sched_wb_vld_i & (r_starve_cnt == 8'(BUS_STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (flush || !bus_sched_wb_vld_i || w_bus_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != 8'hFF) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    // Source selection: starved bus, then buffer head, pipe 0, pipe 1, bus.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_deq      = 1'b0;
        w_enq0     = 1'b0;
        w_enq1     = 1'b0;
        w_bus_gnt  = 1'b0;
        if (!rstn || flush) begin
            w_sel_vld = 1'b0;
        end else if (w_starve) begin
            w_bus_gnt  = 1'b1;
            w_sel_vld  = 1'b1;
            w_sel_addr = bus_sched_wb_rd_addr_i;
            w_sel_data = bus_sched_wb_data_i;
            w_enq0     = w_v0;
            w_enq1     = w_v1;
        end else if (!w_empty) begin
            w_deq      = 1'b1;
            w_sel_vld  = 1'b1;
            w_sel_addr = r_buf_addr[r_rd_ptr];
            w_sel_data = r_buf_data[r_rd_ptr];
            w_enq0     = w_v0;
            w_enq1     = w_v1;
        end else if (w_v0) begin
            w_sel_vld  = 1'b1;
            w_sel_addr = w_p0_addr;
            w_sel_data = w_p0_data;
            w_enq1     = w_v1;
        end else if (w_v1) begin
            w_sel_vld  = 1'b1;
            w_sel_addr = w_p1_addr;
            w_sel_data = w_p1_data;
        end else if (bus_sched_wb_vld_i) begin
            w_bus_gnt  = 1'b1;
            w_sel_vld  = 1'b1;
            w_sel_addr = bus_sched_wb_rd_addr_i;
            w_sel_data = bus_sched_wb_data_i;
        end
    end

    assign w_enq_n    = {1'b0, w_enq0} + {1'b0, w_enq1};
    assign w_wr_ptr_b = r_wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_deq);
            r_wr_ptr <= r_wr_ptr + PW'(w_enq_n);
            r_cnt    <= r_cnt + CW'(w_enq_n) - CW'(w_deq);
        end
    end

    // Pipe 0 takes the first free slot when both pipes enqueue together.
    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_buf_addr[r_wr_ptr] <= w_p0_addr;
            r_buf_data[r_wr_ptr] <= w_p0_data;
        end else if (w_enq1) begin
            r_buf_addr[r_wr_ptr] <= w_p1_addr;
            r_buf_data[r_wr_ptr] <= w_p1_data;
        end
        if (w_enq0 && w_enq1) begin
            r_buf_addr[w_wr_ptr_b] <= w_p1_addr;
            r_buf_data[w_wr_ptr_b] <= w_p1_data;
        end
    end

    // Stage boundary: selected source registered onto the PRF write port.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prf_vld_p1  <= 1'b0;
            r_prf_addr_p1 <= '0;
            r_prf_data_p1 <= '0;
        end else begin
            r_prf_vld_p1  <= w_sel_vld;
            r_prf_addr_p1 <= w_sel_addr;
            r_prf_data_p1 <= w_sel_data;
        end
    end

    assign sched_prf_wb_vld_o     = r_prf_vld_p1;
    assign sched_prf_wb_rd_addr_o = r_prf_addr_p1;
    assign sched_prf_wb_data_o    = r_prf_data_p1;

endmodule
